// File: rtl/vga_scan_pkg.sv
// Shared types and constants for the VGA raster timing stage.
package vga_scan_pkg;

    // Coordinate and colour widths seen on the vga_scan ports.
    localparam int unsigned CNT_W = 11;
    localparam int unsigned RGB_W = 12;

    // Default 640x480@60 timing (25.175 MHz pixel clock).
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef logic [CNT_W-1:0] coord_t;

    // RGB444 field split of the 12-bit colour word, red in the top nibble.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Per-pixel attributes carried alongside the draw-stage latency.
    typedef struct packed {
        logic on;
        logic hs;
        logic vs;
    } sync_bits_t;

    // Blank pixel with both syncs inactive (high).
    localparam sync_bits_t SYNC_IDLE = '{on: 1'b0, hs: 1'b1, vs: 1'b1};

    // True while lo <= pos < hi.
    function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register advancing only when en is high.
module vga_delay_line #(
    parameter int unsigned     WIDTH   = 1,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enable; every stage resets to RST_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan.sv
// Raster timing: pixel tick, x/y scan counters, sync decode and the output
// registers that keep colour, blanking and syncs aligned behind the draw stage.
module vga_scan
    import vga_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    // Draw-stage latency in pixel ticks, 1..4.
    parameter int unsigned PIX_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] color_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        video_on,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hs,
    output logic        vs
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS     = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS     = coord_t'(V_ACTIVE);
    localparam coord_t H_SYNC_LO = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t H_SYNC_HI = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t V_SYNC_LO = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t V_SYNC_HI = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    // A one-bit divider is kept for CLK_DIV == 1; it simply stays at zero.
    localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    logic       fs_q, fs_d;

    sync_bits_t sync_now;
    sync_bits_t sync_tail;

    rgb444_t    rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;

    // ------------------------------------------------------------------
    // Pixel tick
    // ------------------------------------------------------------------
    assign tick = (div_q == DIV_LAST);

    // Divider wraps on the tick cycle.
    always_comb begin
        div_d = div_q + 1'b1;
        if (tick) begin
            div_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    // Advance x/y on tick; flag the tick that loads (0,0) for frame_start.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        fs_d = 1'b0;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Counter and frame_start registers; reset load does not pulse frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            fs_q <= fs_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;

    // ------------------------------------------------------------------
    // Raw per-pixel attributes for the current x/y
    // ------------------------------------------------------------------
    assign video_on = (x_q < H_VIS) && (y_q < V_VIS);

    // Decode visibility and active-low syncs for the pixel now on x/y.
    always_comb begin
        sync_now    = SYNC_IDLE;
        sync_now.on = video_on;
        sync_now.hs = ~in_window(x_q, H_SYNC_LO, H_SYNC_HI);
        sync_now.vs = ~in_window(y_q, V_SYNC_LO, V_SYNC_HI);
    end

    // Holds the attributes back until the matching colour returns.
    vga_delay_line #(
        .WIDTH   ($bits(sync_bits_t)),
        .DEPTH   (PIX_LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .din   (sync_now),
        .dout  (sync_tail)
    );

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    // Sample colour and syncs together on tick; colour is forced to 0 when blank.
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (tick) begin
            rgb_d = sync_tail.on ? rgb444_t'(color_in) : '0;
            hs_d  = sync_tail.hs;
            vs_d  = sync_tail.vs;
        end
    end

    // Pin registers; reset drives blank colour and inactive syncs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;
    assign hs    = hs_q;
    assign vs    = vs_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan on a shrunken raster so whole frames fit in a short run.
// The bench plays the draw stage: it sees each pixel as it is presented,
// queues the colour it will return PIX_LAT ticks later, and queues the
// expected pin values for that pixel, checked PIX_LAT+1 ticks later.
module tb_vga_scan;

    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int PIX_LAT  = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] color_in = 12'h000;
    logic [10:0] x, y;
    logic        video_on, frame_start, hs, vs;
    logic [3:0]  vga_r, vga_g, vga_b;

    exp_t        exp_q[$];
    logic [11:0] col_q[$];
    int          tick_cnt = 0;
    int          color_mode = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    vga_scan #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_LAT  (PIX_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .color_in    (color_in),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hs          (hs),
        .vs          (vs)
    );

    // ---------------- reference model (pixel index -> raster) ----------------
    function automatic int px(input int q);
        return q % H_TOTAL;
    endfunction

    function automatic int py(input int q);
        return (q / H_TOTAL) % V_TOTAL;
    endfunction

    function automatic logic pix_on(input int q);
        return (px(q) < H_ACTIVE) && (py(q) < V_ACTIVE);
    endfunction

    function automatic logic [11:0] pick_color(input int q);
        if (color_mode == 1) return 12'hFFF;
        if (px(q) == 5 && py(q) == 0) return 12'hF0A;
        return 12'((q * 421 + 97) % 4093) | 12'h001;
    endfunction

    function automatic exp_t pixel_exp(input int q, input logic [11:0] c);
        exp_t e;
        e.rgb = pix_on(q) ? c : 12'h000;
        e.hs  = !(px(q) >= H_ACTIVE + H_FP && px(q) < H_ACTIVE + H_FP + H_SYNC);
        e.vs  = !(py(q) >= V_ACTIVE + V_FP && py(q) < V_ACTIVE + V_FP + V_SYNC);
        return e;
    endfunction

    // Draw stage sees pixel tick_cnt on x/y now.
    task automatic present_pixel();
        logic [11:0] c;
        c = pick_color(tick_cnt);
        col_q.push_back(c);
        exp_q.push_back(pixel_exp(tick_cnt, c));
    endtask

    task automatic model_restart();
        tick_cnt = 0;
        col_q.delete();
        exp_q.delete();
        present_pixel();
    endtask

    // Advance one pixel tick, starting and ending on a negedge just after a tick.
    task automatic step_tick();
        exp_t        e;
        logic [13:0] got;
        logic        fs_exp;
        if (tick_cnt >= PIX_LAT) color_in = col_q.pop_front();
        else                     color_in = 12'hA5A;
        for (int c = 0; c < CLK_DIV; c++) begin
            @(negedge clk);
            fs_exp = (c == CLK_DIV - 1) && ((tick_cnt + 1) % FRAME == 0);
            n_checks++;
            if (frame_start !== fs_exp) begin
                n_fail++;
                $display("FAIL frame_start tick %0d clk %0d: got %b want %b",
                         tick_cnt, c, frame_start, fs_exp);
            end
            if (c < CLK_DIV - 1) begin
                n_checks++;
                if (x !== 11'(px(tick_cnt))) begin
                    n_fail++;
                    $display("FAIL x_between_ticks tick %0d clk %0d: got %0d want %0d",
                             tick_cnt, c, x, px(tick_cnt));
                end
            end
        end
        tick_cnt++;
        n_checks++;
        if (x !== 11'(px(tick_cnt)) || y !== 11'(py(tick_cnt))) begin
            n_fail++;
            $display("FAIL xy tick %0d: got (%0d,%0d) want (%0d,%0d)",
                     tick_cnt, x, y, px(tick_cnt), py(tick_cnt));
        end
        n_checks++;
        if (video_on !== pix_on(tick_cnt)) begin
            n_fail++;
            $display("FAIL video_on tick %0d: got %b want %b", tick_cnt, video_on,
                     pix_on(tick_cnt));
        end
        present_pixel();
        if (tick_cnt >= PIX_LAT + 1) e = exp_q.pop_front();
        else                         e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
        got = {vga_r, vga_g, vga_b, hs, vs};
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL pins tick %0d: got rgb=%03h hs=%b vs=%b want rgb=%03h hs=%b vs=%b",
                     tick_cnt, got[13:2], got[1], got[0], e.rgb, e.hs, e.vs);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        color_in = 12'hFFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if (x !== 11'd0 || y !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y);
        end
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rgb: got %03h want 000", {vga_r, vga_g, vga_b});
        end
        n_checks++;
        if (hs !== 1'b1 || vs !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hs, vs);
        end
        n_checks++;
        if (frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_start: got %b want 0", frame_start);
        end
        n_checks++;
        if (video_on !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_video_on: got %b want 1", video_on);
        end
    endtask

    task automatic test_first_tick();
        color_mode = 0;
        rst_n      = 1'b1;
        model_restart();
        step_tick();
        n_checks++;
        if (x !== 11'd1 || y !== 11'd0) begin
            n_fail++;
            $display("FAIL first_tick_xy: got (%0d,%0d) want (1,0)", x, y);
        end
        n_checks++;
        if (hs !== 1'b1 || vs !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL first_tick_pins: got hs=%b vs=%b rgb=%03h want 1 1 000",
                     hs, vs, {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_alignment();
        while (tick_cnt < 5 + PIX_LAT + 1) step_tick();
        n_checks++;
        if (vga_r !== 4'hF || vga_g !== 4'h0 || vga_b !== 4'hA) begin
            n_fail++;
            $display("FAIL align_F0A: got r=%h g=%h b=%h want F 0 A", vga_r, vga_g, vga_b);
        end
    endtask

    task automatic test_line_wrap();
        int y0;
        int lows;
        int first;
        int q;
        while (px(tick_cnt) != H_TOTAL - 1) step_tick();
        y0 = py(tick_cnt);
        step_tick();
        n_checks++;
        if (x !== 11'd0 || y !== 11'(y0 + 1)) begin
            n_fail++;
            $display("FAIL line_wrap: got (%0d,%0d) want (0,%0d)", x, y, y0 + 1);
        end
        lows  = 0;
        first = 9999;
        for (int i = 0; i < H_TOTAL; i++) begin
            step_tick();
            q = tick_cnt - PIX_LAT - 1;
            if (hs === 1'b0) begin
                lows++;
                if (px(q) < first) first = px(q);
            end
        end
        n_checks++;
        if (lows != H_SYNC) begin
            n_fail++;
            $display("FAIL hs_width: got %0d want %0d", lows, H_SYNC);
        end
        n_checks++;
        if (first != H_ACTIVE + H_FP) begin
            n_fail++;
            $display("FAIL hs_start_pixel: got %0d want %0d", first, H_ACTIVE + H_FP);
        end
    endtask

    task automatic test_blanking();
        int leaked;
        int lit;
        int q;
        color_mode = 1;
        for (int i = 0; i < PIX_LAT + 1; i++) step_tick();
        leaked = 0;
        lit    = 0;
        for (int i = 0; i < FRAME; i++) begin
            step_tick();
            q = tick_cnt - PIX_LAT - 1;
            if (!pix_on(q) && {vga_r, vga_g, vga_b} !== 12'h000) leaked++;
            if ({vga_r, vga_g, vga_b} === 12'hFFF) lit++;
        end
        color_mode = 0;
        n_checks++;
        if (leaked != 0) begin
            n_fail++;
            $display("FAIL blank_leak: got %0d lit blank pixels want 0", leaked);
        end
        n_checks++;
        if (lit != H_ACTIVE * V_ACTIVE) begin
            n_fail++;
            $display("FAIL active_lit: got %0d want %0d", lit, H_ACTIVE * V_ACTIVE);
        end
    endtask

    task automatic test_frame_wrap();
        int lows;
        int first;
        int q;
        for (int i = 0; i < FRAME; i++) begin
            if (px(tick_cnt) == H_TOTAL - 1 && py(tick_cnt) == V_TOTAL - 1) break;
            step_tick();
        end
        step_tick();
        n_checks++;
        if (x !== 11'd0 || y !== 11'd0) begin
            n_fail++;
            $display("FAIL frame_wrap_xy: got (%0d,%0d) want (0,0)", x, y);
        end
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_wrap_pulse: got %b want 1", frame_start);
        end
        lows  = 0;
        first = 9999;
        for (int i = 0; i < FRAME; i++) begin
            step_tick();
            q = tick_cnt - PIX_LAT - 1;
            if (vs === 1'b0) begin
                lows++;
                if (py(q) < first) first = py(q);
            end
        end
        n_checks++;
        if (lows != V_SYNC * H_TOTAL) begin
            n_fail++;
            $display("FAIL vs_width: got %0d want %0d", lows, V_SYNC * H_TOTAL);
        end
        n_checks++;
        if (first != V_ACTIVE + V_FP) begin
            n_fail++;
            $display("FAIL vs_start_line: got %0d want %0d", first, V_ACTIVE + V_FP);
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < FRAME; i++) begin
            if (px(tick_cnt) == 10 && py(tick_cnt) == 5) break;
            step_tick();
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (x !== 11'd0 || y !== 11'd0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_counters: got (%0d,%0d) fs=%b want (0,0) fs=0",
                     x, y, frame_start);
        end
        n_checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || hs !== 1'b1 || vs !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pins: got rgb=%03h hs=%b vs=%b want 000 1 1",
                     {vga_r, vga_g, vga_b}, hs, vs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_restart();
        step_tick();
        n_checks++;
        if (x !== 11'd1 || y !== 11'd0 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_restart: got (%0d,%0d) rgb=%03h want (1,0) 000",
                     x, y, {vga_r, vga_g, vga_b});
        end
        for (int i = 0; i < 2 * H_TOTAL; i++) step_tick();
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_alignment();
        test_line_wrap();
        test_blanking();
        test_frame_wrap();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
